deser_rr_collector: RTL and testbench
=====================================

// Module: deser_rr_collector
// PURPOSE
//  Round-robin collector for NCH 1-to-14 deserializer channels. Watches each channel's ready, latches
//  the winner's parallel word into one output register, pulses that channel's Ack for exactly one
//  cycle, and presents the word downstream with a valid/ready handshake. Sits between the
//  deserializer bank (ready/Ack/data_out per channel) and the single consumer of received words.
// PARAMETERS
//  NCH  4   number of deserializer channels (2..8)
//  DW   14  word width per channel
//  CW   2   channel-index width, >= clog2(NCH)
// PORTS
//  clock      in   1        single clock; all logic on posedge
//  reset      in   1        synchronous, active-high reset
//  ch_ready   in   NCH      per-channel ready (high while deserializer holds a word)
//  ch_data    in   NCH*DW   channel i word on [i*DW +: DW]
//  ch_enable  in   NCH      per-channel enable; disabled channels never granted
//  ch_ack     out  NCH      one-hot, one-cycle Ack to the granted channel
//  out_data   out  DW       captured word
//  out_chan   out  CW       source channel of out_data
//  out_valid  out  1        out_data/out_chan valid
//  out_ready  in   1        consumer accepts word when out_valid & out_ready
//  word_count out  16       words accepted downstream, wraps 0xFFFF->0
//  stall_cnt  out  16       cycles with out_valid & !out_ready, saturates at 0xFFFF
// BEHAVIOUR
//  Reset (reset=1 at posedge): state=IDLE, ch_ack=0, out_valid=0, out_data=0, out_chan=0,
//   last_grant=NCH-1 (ch0 highest priority first), word_count=0, stall_cnt=0. Reset wins over all.
//  FSM, two states:
//   IDLE: req = ch_ready & ch_enable. slot_free = !out_valid | out_ready.
//     if |req & slot_free: winner = first set req bit scanning last_grant+1, +2 .. wrapping mod NCH;
//     capture out_data<=ch_data[winner], out_chan<=winner, out_valid<=1, last_grant<=winner; ->ACK.
//     else stay IDLE.
//   ACK: ch_ack = onehot(last_grant) for this one cycle; ->IDLE unconditionally.
//  ch_ack decoded from registered state only (no combinational path from ch_ready); zero outside ACK.
//  Deserializer drops ready the cycle after it sees Ack, so IDLE after ACK never re-sees the acked
//   channel's stale ready; no extra settle state.
//  Latency: ch_ready high in cycle T (slot free) -> out_valid high and ch_ack high in T+1 -> earliest
//   next grant in T+2. Peak throughput 1 word / 2 cycles.
//  Output register: out_valid clears on out_valid & out_ready unless a new capture in the same cycle
//   (then stays 1, data replaced). out_data/out_chan stable while out_valid & !out_ready.
//  Backpressure: while out_valid & !out_ready, no grant; channels keep ready and hold data (no loss).
//  ch_enable dropping while a channel waits: not granted; if dropped during ACK, Ack still completes.
//  Arbitration ignores ch_data; out_chan is the sole source of channel identity.
//  word_count += 1 on each out_valid & out_ready; 16-bit wrap.
//  stall_cnt += 1 each out_valid & !out_ready cycle, saturating; cleared only by reset.
//  Reset during ACK: Ack suppressed; the channel keeps ready and is re-served after reset, not lost.
// TESTING
//  1 reset, ch_ready=0: all outputs 0 for 10 cycles; ch_ack never asserts.
//  2 ch_ready=4'b0100, data ch2=14'h1ABC, out_ready=1 -> next cycle out_valid=1, out_data=14'h1ABC,
//    out_chan=2, ch_ack=4'b0100 for one cycle; word_count=1 after accept.
//  3 all four ready from reset, out_ready=1, each drops ready after Ack -> grants in order 0,1,2,3,
//    2 cycles apart; word_count=4; never two ack bits high together.
//  4 ch0 and ch3 continuously re-asserting -> grants alternate 0,3,0,3 (no starvation).
//  5 out_ready=0 for 20 cycles with word pending and ch1 ready -> out_data stable, no ch_ack,
//    stall_cnt=20; raise out_ready -> ch1 granted next cycle.
//  6 ch_enable=4'b1101, ch1 ready -> never acked; assert reset in ACK cycle -> ch_ack=0, outputs reset.

Source files
------------

// File: rtl/deser_rr_collector.sv
// Round-robin collector: grants one ready deserializer channel at a time, captures its word,
// acks it for one cycle and presents the word downstream through a valid/ready register.
module deser_rr_collector #(
  parameter int NCH = 4,
  parameter int DW  = 14,
  parameter int CW  = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NCH-1:0]    ch_ready_i,
  input  logic [NCH*DW-1:0] ch_data_i,
  input  logic [NCH-1:0]    ch_enable_i,
  output logic [NCH-1:0]    ch_ack_o,
  output logic [DW-1:0]     out_data_o,
  output logic [CW-1:0]     out_chan_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0]       word_count_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     word_count_q, word_count_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [NCH-1:0]  req_s;
  logic            slot_free_s;
  logic            accept_s;
  logic            capture_s;
  logic            found_s;
  logic [CW-1:0]   winner_s;
  int              idx_s;

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    req_s    = ch_ready_i & ch_enable_i;
    found_s  = 1'b0;
    winner_s = '0;
    idx_s    = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx_s = (int'(last_grant_q) + k) % NCH;
      if (!found_s && req_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = CW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state logic for the FSM, output register and counters.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    word_count_d = word_count_q;
    stall_cnt_d  = stall_cnt_q;

    slot_free_s  = !out_valid_q || out_ready_i;
    accept_s     = out_valid_q && out_ready_i;
    capture_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (found_s && slot_free_s) begin
          capture_s = 1'b1;
          state_d   = ACK;
        end else begin
          state_d   = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A capture in the same cycle as an accept keeps valid high with fresh data.
    if (capture_s) begin
      out_data_d   = ch_data_i[winner_s*DW +: DW];
      out_chan_d   = winner_s;
      out_valid_d  = 1'b1;
      last_grant_d = winner_s;
    end else if (accept_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end

    if (accept_s) begin
      word_count_d = word_count_q + 16'd1;
    end else begin
      word_count_d = word_count_q;
    end

    if (out_valid_q && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= CW'(NCH - 1);
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= 16'd0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Ack decoded from registered state; masked by reset so an interrupted Ack is never seen.
  always_comb begin
    ch_ack_o = '0;
    if ((state_q == ACK) && !reset_i) begin
      ch_ack_o[last_grant_q] = 1'b1;
    end else begin
      ch_ack_o = '0;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_chan_o   = out_chan_q;
  assign out_valid_o  = out_valid_q;
  assign word_count_o = word_count_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_deser_rr_collector.sv
// Directed and randomized bench for deser_rr_collector with a cycle-level reference model
// and an emulation of the deserializer channels (ready held until Ack, then dropped).
module tb_deser_rr_collector;
  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int CW  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    ch_ack;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       word_count;
  logic [15:0]       stall_cnt;

  always #5 clock = ~clock;

  deser_rr_collector #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .ch_ready_i   (ch_ready),
    .ch_data_i    (ch_data),
    .ch_enable_i  (ch_enable),
    .ch_ack_o     (ch_ack),
    .out_data_o   (out_data),
    .out_chan_o   (out_chan),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .word_count_o (word_count),
    .stall_cnt_o  (stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int glog[$];
  int gtime[$];

  // Reference model state: what the collector should be holding / doing.
  bit          m_valid;
  bit          m_in_ack;
  int          m_last;
  logic [DW-1:0] m_data;
  int          m_chan;
  int unsigned m_wc;
  int unsigned m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_update();
    bit acc;
    bit grant;
    int w;
    acc   = 1'b0;
    grant = 1'b0;
    w     = 0;
    if (reset) begin
      m_valid = 1'b0; m_in_ack = 1'b0; m_last = NCH - 1;
      m_data = '0; m_chan = 0; m_wc = 0; m_stall = 0;
    end else begin
      acc = m_valid && out_ready;
      if (m_valid && !out_ready && m_stall < 65535) m_stall++;
      if (acc) m_wc = (m_wc + 1) % 65536;
      if (!m_in_ack && (!m_valid || out_ready)) begin
        for (int k = 1; k <= NCH; k++) begin
          w = (m_last + k) % NCH;
          if (ch_ready[w] && ch_enable[w]) begin
            grant = 1'b1;
            break;
          end
        end
      end
      if (grant) begin
        m_data = ch_data[w*DW +: DW]; m_chan = w; m_valid = 1'b1;
        m_last = w; m_in_ack = 1'b1;
      end else begin
        m_in_ack = 1'b0;
        if (acc) m_valid = 1'b0;
      end
    end
  endtask

  // One clock: compare against the model mid-cycle, advance the model at the edge,
  // then let channels that saw an Ack drop their ready.
  task automatic step();
    logic [NCH-1:0] acked;
    logic [NCH-1:0] exp_ack;
    @(negedge clock);
    exp_ack = '0;
    if (m_in_ack && !reset) exp_ack[m_last] = 1'b1;
    chk("ack", 32'(ch_ack), 32'(exp_ack));
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("data", 32'(out_data), 32'(m_data));
    chk("chan", 32'(out_chan), 32'(m_chan));
    chk("word_count", 32'(word_count), m_wc);
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    acked = ch_ack;
    for (int i = 0; i < NCH; i++) begin
      if (acked[i]) begin
        glog.push_back(i);
        gtime.push_back(cyc);
      end
    end
    @(posedge clock);
    model_update();
    cyc++;
    #1;
    ch_ready = ch_ready & ~acked;
  endtask

  task automatic raise(input int ch, input logic [DW-1:0] d);
    ch_ready[ch] = 1'b1;
    ch_data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    glog.delete();
    gtime.delete();
  endtask

  logic [DW-1:0] d0;

  initial begin
    reset     = 1'b1;
    ch_ready  = '0;
    ch_data   = '0;
    ch_enable = 4'b1111;
    out_ready = 1'b1;

    // 1: reset held, nothing ready
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_ack", 32'(ch_ack), 32'd0);
      chk("t1_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b0;

    // 2: single channel 2
    raise(2, 14'h1ABC);
    step();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h1ABC);
    chk("t2_chan", 32'(out_chan), 32'd2);
    chk("t2_ack", 32'(ch_ack), 32'b0100);
    step();
    chk("t2_ack_off", 32'(ch_ack), 32'd0);
    chk("t2_wc", 32'(word_count), 32'd1);

    // 3: all four ready from reset
    do_reset();
    for (int i = 0; i < NCH; i++) raise(i, DW'($urandom));
    for (int i = 0; i < 8; i++) step();
    chk("t3_ngrants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++) chk("t3_order", 32'(glog[i]), 32'(i));
    for (int i = 1; i < gtime.size(); i++) chk("t3_gap", 32'(gtime[i] - gtime[i-1]), 32'd2);
    chk("t3_wc", 32'(word_count), 32'd4);

    // 4: ch0 and ch3 keep re-asserting
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (!ch_ready[0]) raise(0, DW'($urandom));
      if (!ch_ready[3]) raise(3, DW'($urandom));
      step();
    end
    chk("t4_ngrants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++) chk("t4_alt", 32'(glog[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
    ch_ready = '0;

    // 5: backpressure for 20 cycles
    do_reset();
    d0 = DW'($urandom);
    raise(0, d0);
    out_ready = 1'b0;
    step();
    step();
    raise(1, DW'($urandom));
    glog.delete();
    for (int i = 0; i < 19; i++) begin
      step();
      chk("t5_stable", 32'(out_data), 32'(d0));
    end
    chk("t5_noack", 32'(glog.size()), 32'd0);
    chk("t5_stall", 32'(stall_cnt), 32'd20);
    out_ready = 1'b1;
    step();
    chk("t5_chan", 32'(out_chan), 32'd1);
    chk("t5_ack", 32'(ch_ack), 32'b0010);
    step();

    // 6: disabled channel and reset during ACK
    do_reset();
    ch_enable = 4'b1101;
    ch_ready  = '0;
    raise(1, DW'($urandom));
    for (int i = 0; i < 6; i++) step();
    chk("t6_disabled", 32'(glog.size()), 32'd0);
    raise(0, DW'($urandom));
    step();
    reset = 1'b1;
    #1;
    chk("t6_ack_masked", 32'(ch_ack), 32'd0);
    step();
    chk("t6_valid_rst", 32'(out_valid), 32'd0);
    chk("t6_wc_rst", 32'(word_count), 32'd0);
    reset = 1'b0;
    step();
    chk("t6_reserve_valid", 32'(out_valid), 32'd1);
    chk("t6_reserve_ack", 32'(ch_ack), 32'b0001);
    step();

    // Randomized traffic against the model
    ch_enable = 4'b1111;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_ready[i] && $urandom_range(0, 3) == 0) raise(i, DW'($urandom));
      end
      if ($urandom_range(0, 9) == 0) ch_enable = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
